// File: rtl/text_console_pkg.sv
// Shared state encoding and character codes for the text console.
package text_console_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_CLEAR  = 2'd0;
    localparam state_t ST_IDLE   = 2'd1;
    localparam state_t ST_CLRROW = 2'd2;

    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_console_ram.sv
// Simple dual-port character buffer: one write port, one registered read port.
module text_console_ram #(
    parameter int DEPTH  = 3200,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    // Read-before-write on a same-address collision returns the old byte.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_console.sv
// Character-cell text console: host byte stream into a circular-row buffer,
// read back per font cell as a 1-bit overlay with a blinking cursor.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_CLEAR  | fill every cell with space, then home cursor and scroll
// ST_IDLE   | in_ready high; decode one host byte per transfer
// ST_CLRROW | blank the new bottom physical row after a scroll
module text_console
    import text_console_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int ROWS       = 40,
    parameter int BLINK_LOG2 = 5,
    parameter int CURSOR_EN  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    input  logic         vsync,
    input  logic [7:0]   char_x,
    input  logic [7:0]   char_y,
    input  logic [255:0] ascii_char,
    output logic [7:0]   cursor_x,
    output logic [7:0]   cursor_y,
    output logic         out
);

    localparam int             DEPTH    = COLS * ROWS;
    localparam int             ADDR_W   = $clog2(DEPTH);
    localparam logic [7:0]     LAST_COL = 8'(COLS - 1);
    localparam logic [7:0]     LAST_ROW = 8'(ROWS - 1);
    localparam logic [15:0]    CLR_LAST = 16'(DEPTH - 1);
    localparam logic [15:0]    ROW_LAST = 16'(COLS - 1);
    localparam logic           CUR_ON   = (CURSOR_EN != 0);

    state_t            state;
    logic [15:0]       clr_cnt;
    logic [7:0]        top_row;
    logic              accept;
    logic              adv_row;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [7:0]        code_q;
    logic              win;
    logic              hit;
    logic              win_q;
    logic              hit_q;
    logic              vsync_d;
    logic [BLINK_LOG2:0] frame_cnt;
    logic              pel;

    // Screen row is rotated by top_row so scrolling never moves stored data.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] row,
                                                   input logic [7:0] col,
                                                   input logic [7:0] top);
        logic [8:0]  phys;
        logic [15:0] lin;
        phys = {1'b0, row} + {1'b0, top};
        if (phys >= 9'(ROWS)) begin
            phys = phys - 9'(ROWS);
        end
        lin = 16'(phys) * 16'(COLS) + {8'd0, col};
        return lin[ADDR_W-1:0];
    endfunction

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        adv_row = 1'b0;
        if (accept) begin
            if (in_data == CH_LF) begin
                adv_row = 1'b1;
            end else if (is_printable(in_data) && (cursor_x == LAST_COL)) begin
                adv_row = 1'b1;
            end
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_cnt[ADDR_W-1:0];
        ram_wdata = CH_SPACE;
        case (state)
            ST_CLEAR: ram_we = 1'b1;
            ST_CLRROW: begin
                ram_we    = 1'b1;
                ram_waddr = cell_addr(LAST_ROW, clr_cnt[7:0], top_row);
            end
            ST_IDLE: begin
                if (accept && is_printable(in_data)) begin
                    ram_we    = 1'b1;
                    ram_waddr = cell_addr(cursor_y, cursor_x, top_row);
                    ram_wdata = in_data;
                end
            end
            default: ram_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            top_row  <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 16'd1;
                    end
                end
                ST_CLRROW: begin
                    if (clr_cnt == ROW_LAST) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 16'd1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (is_printable(in_data)) begin
                            cursor_x <= (cursor_x == LAST_COL) ? 8'd0 : cursor_x + 8'd1;
                        end else if ((in_data == CH_LF) || (in_data == CH_CR)) begin
                            cursor_x <= 8'd0;
                        end else if ((in_data == CH_BS) && (cursor_x != 8'd0)) begin
                            cursor_x <= cursor_x - 8'd1;
                        end else if (in_data == CH_FF) begin
                            state    <= ST_CLEAR;
                            clr_cnt  <= '0;
                            cursor_x <= '0;
                            cursor_y <= '0;
                            top_row  <= '0;
                        end
                        if (adv_row) begin
                            if (cursor_y != LAST_ROW) begin
                                cursor_y <= cursor_y + 8'd1;
                            end else begin
                                top_row <= (top_row == LAST_ROW) ? 8'd0 : top_row + 8'd1;
                                state   <= ST_CLRROW;
                                clr_cnt <= '0;
                            end
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign win       = (char_x < 8'(COLS)) && (char_y < 8'(ROWS));
    assign hit       = (char_x == cursor_x) && (char_y == cursor_y);
    assign ram_raddr = win ? cell_addr(char_y, char_x, top_row) : '0;

    text_console_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (code_q)
    );

    // code_q lines up with ascii_char, which the font generator registers.
    assign pel = ascii_char[code_q] & win_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q     <= 1'b0;
            hit_q     <= 1'b0;
            out       <= 1'b0;
            vsync_d   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            win_q   <= win;
            hit_q   <= hit;
            out     <= pel ^ (CUR_ON & hit_q & win_q & frame_cnt[BLINK_LOG2]);
            vsync_d <= vsync;
            if (vsync && !vsync_d) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench: random host byte stream against a screen-array model,
// overlay readback through the display path with random font patterns.
module tb_text_console;

    localparam int COLS       = 80;
    localparam int ROWS       = 40;
    localparam int BLINK_LOG2 = 5;
    localparam int CURSOR_EN  = 1;
    localparam int DEPTH      = COLS * ROWS;
    localparam int LIMIT      = DEPTH + 200;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_ready;
    logic         vsync = 1'b0;
    logic [7:0]   char_x = 8'd0;
    logic [7:0]   char_y = 8'd0;
    logic [255:0] ascii_char = '0;
    logic [7:0]   cursor_x;
    logic [7:0]   cursor_y;
    logic         out;

    text_console #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .BLINK_LOG2 (BLINK_LOG2),
        .CURSOR_EN  (CURSOR_EN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .vsync      (vsync),
        .char_x     (char_x),
        .char_y     (char_y),
        .ascii_char (ascii_char),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .out        (out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: screen held in screen coordinates; scrolling shifts rows up.
    byte unsigned scr [ROWS][COLS];
    int cx, cy, frames;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                scr[y][x] = 8'h20;
        cx = 0;
        cy = 0;
    endfunction

    function automatic int model_newline();
        if (cy < ROWS - 1) begin
            cy++;
            return 0;
        end
        for (int y = 0; y < ROWS - 1; y++)
            for (int x = 0; x < COLS; x++)
                scr[y][x] = scr[y+1][x];
        for (int x = 0; x < COLS; x++)
            scr[ROWS-1][x] = 8'h20;
        return COLS;
    endfunction

    // Applies one accepted byte; returns the expected in_ready-low cycles after it.
    function automatic int model_byte(input logic [7:0] b);
        int busy;
        busy = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[cy][cx] = b;
            cx++;
            if (cx == COLS) begin
                cx = 0;
                busy = model_newline();
            end
        end else if (b == 8'h0A) begin
            cx = 0;
            busy = model_newline();
        end else if (b == 8'h0D) begin
            cx = 0;
        end else if (b == 8'h08) begin
            if (cx > 0) cx--;
        end else if (b == 8'h0C) begin
            model_clear();
            busy = DEPTH;
        end
        return busy;
    endfunction

    function automatic logic exp_pel(input int x, input int y);
        logic pel, cur, blink;
        if (x >= COLS || y >= ROWS) return 1'b0;
        pel   = ascii_char[scr[y][x]];
        blink = ((frames >> BLINK_LOG2) & 1) == 1;
        cur   = (CURSOR_EN != 0) && (x == cx) && (y == cy) && blink;
        return pel ^ cur;
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n, busy;
        wait_ready(n);
        if (n >= LIMIT) check_val("ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        busy = model_byte(b);
        check_val("cursor_x", cursor_x, cx);
        check_val("cursor_y", cursor_y, cy);
        wait_ready(n);
        check_val("busy", n, busy);
    endtask

    // Streams one cell per cycle; out for a cell appears two cycles later.
    task automatic scan(input string tag);
        logic exp_q[$];
        for (int y = 0; y <= ROWS; y++) begin
            for (int x = 0; x <= COLS; x++) begin
                @(negedge clk);
                if (exp_q.size() == 2) check_val(tag, out, exp_q.pop_front());
                char_x = 8'(x);
                char_y = 8'(y);
                exp_q.push_back(exp_pel(x, y));
            end
        end
        repeat (2) begin
            @(negedge clk);
            check_val(tag, out, exp_q.pop_front());
        end
    endtask

    task automatic probe(input string tag, input int x, input int y);
        char_x = 8'(x);
        char_y = 8'(y);
        @(negedge clk);
        @(negedge clk);
        check_val(tag, out, exp_pel(x, y));
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        frames++;
    endtask

    function automatic logic [255:0] rand_pattern();
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = $urandom();
        return p;
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        frames = 0;
        model_clear();

        // Hold in_valid with an ignored code through reset and the initial clear.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_ready", in_ready, 0);
        check_val("rst_out", out, 0);
        check_val("rst_cx", cursor_x, 0);
        check_val("rst_cy", cursor_y, 0);
        reset = 1'b0;
        wait_ready(n);
        check_val("clear_busy", n, DEPTH);
        @(negedge clk);
        in_valid = 1'b0;
        void'(model_byte(8'h00));

        ascii_char = rand_pattern();
        scan("scan_blank");

        send(8'h41);
        send(8'h42);
        ascii_char = '0;
        ascii_char[8'h41] = 1'b1;
        probe("ab_lit", 0, 0);
        ascii_char = '1;
        ascii_char[8'h41] = 1'b0;
        probe("ab_dark", 0, 0);
        probe("ab_b", 1, 0);

        repeat (COLS - 2) send(8'h78);
        check_val("wrap_x", cursor_x, 0);
        check_val("wrap_y", cursor_y, 1);
        send(8'h0D);
        send(8'h0A);
        send(8'h08);
        check_val("ctl_y", cursor_y, 2);

        for (int i = 0; i < 1000; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 65)      b = 8'($urandom_range(32, 126));
            else if (r < 77) b = 8'h0A;
            else if (r < 83) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else if (r < 95) b = 8'($urandom_range(0, 7));
            else if (r < 99) b = 8'($urandom_range(127, 255));
            else             b = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h09;
            send(b);
        end
        ascii_char = rand_pattern();
        scan("scan_random");

        send(8'h0C);
        for (int r = 0; r < ROWS; r++) begin
            send(8'(8'h41 + r % 26));
            if (r < ROWS - 1) send(8'h0A);
        end
        send(8'h0A);
        check_val("scroll_x", cursor_x, 0);
        check_val("scroll_y", cursor_y, ROWS - 1);
        ascii_char = rand_pattern();
        scan("scan_scroll");

        send(8'h51);
        send(8'h0C);
        repeat (ROWS - 1) send(8'h0A);
        send(8'h5A);
        in_valid = 1'b1;
        in_data  = 8'h0A;
        @(negedge clk);
        in_valid = 1'b0;
        void'(model_byte(8'h0A));
        repeat (10) @(negedge clk);
        check_val("clrrow_busy", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        frames = 0;
        wait_ready(n);
        check_val("reset_clear_busy", n, DEPTH);
        ascii_char = rand_pattern();
        scan("scan_after_reset");

        ascii_char = rand_pattern();
        ascii_char[8'h20] = 1'b0;
        for (int f = 0; f < 64; f++) begin
            probe("blink_blank", 0, 0);
            vsync_pulse();
        end
        ascii_char[8'h20] = 1'b1;
        for (int f = 0; f < 64; f++) begin
            probe("blink_lit", 0, 0);
            vsync_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
